// File: rtl/multicycle_controller.sv
// ============================================================================
// multicycle_controller : FSM sequencing fetch/decode/execute/writeback, rev 1.0
// ============================================================================
`default_nettype none

module multicycle_controller #(
  parameter int XLEN          = 32,
  parameter int CNT_W         = 32,
  parameter int FETCH_TIMEOUT = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             run_enable,
  output logic             mem_req,
  input  logic             mem_ready,
  output logic             ir_we,
  input  logic [XLEN-1:0]  instruction,
  output logic             pc_inc,
  output logic [4:0]       rs1,
  output logic [4:0]       rs2,
  output logic [4:0]       rd,
  output logic [2:0]       alu_op,
  output logic             use_imm,
  output logic [XLEN-1:0]  imm,
  output logic             reg_we,
  output logic [2:0]       state,
  output logic             halted,
  output logic             trap,
  output logic [CNT_W-1:0] cycle_count,
  output logic [CNT_W-1:0] retired_count
);

  localparam logic [2:0] S_FETCH     = 3'd0;
  localparam logic [2:0] S_DECODE    = 3'd1;
  localparam logic [2:0] S_EXECUTE   = 3'd2;
  localparam logic [2:0] S_WRITEBACK = 3'd3;
  localparam logic [2:0] S_HALT      = 3'd4;
  localparam logic [2:0] S_TRAP      = 3'd5;

  localparam logic [2:0] OP_ADD = 3'd0;
  localparam logic [2:0] OP_SUB = 3'd1;
  localparam logic [2:0] OP_AND = 3'd2;
  localparam logic [2:0] OP_OR  = 3'd3;
  localparam logic [2:0] OP_XOR = 3'd4;

  localparam int              TO_W    = $clog2(FETCH_TIMEOUT + 1);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(FETCH_TIMEOUT - 1);

  logic [2:0]       state_q,    state_d;
  logic [TO_W-1:0]  timeout_q,  timeout_d;
  logic [4:0]       rs1_q,      rs1_d;
  logic [4:0]       rs2_q,      rs2_d;
  logic [4:0]       rd_q,       rd_d;
  logic [2:0]       alu_op_q,   alu_op_d;
  logic             use_imm_q,  use_imm_d;
  logic [XLEN-1:0]  imm_q,      imm_d;
  logic             halted_q,   halted_d;
  logic             trap_q,     trap_d;
  logic [CNT_W-1:0] cycle_q,    cycle_d;
  logic [CNT_W-1:0] retired_q,  retired_d;

  logic [6:0] dec_opcode;
  logic [6:0] dec_funct7;
  logic [2:0] dec_funct3;
  logic       dec_legal;
  logic       dec_ecall;
  logic [2:0] dec_op;
  logic       dec_use_imm;

  // Instruction classification, consulted only while in DECODE
  always_comb begin
    dec_opcode  = instruction[6:0];
    dec_funct3  = instruction[14:12];
    dec_funct7  = instruction[31:25];
    dec_legal   = 1'b0;
    dec_ecall   = (instruction == XLEN'(32'h0000_0073));
    dec_op      = OP_ADD;
    dec_use_imm = 1'b0;
    if (dec_opcode == 7'b0110011) begin
      dec_legal = 1'b1;
      case ({dec_funct7, dec_funct3})
        {7'b0000000, 3'b000}: dec_op = OP_ADD;
        {7'b0100000, 3'b000}: dec_op = OP_SUB;
        {7'b0000000, 3'b111}: dec_op = OP_AND;
        {7'b0000000, 3'b110}: dec_op = OP_OR;
        {7'b0000000, 3'b100}: dec_op = OP_XOR;
        default:              dec_legal = 1'b0;
      endcase
    end else if (dec_opcode == 7'b0010011 && dec_funct3 == 3'b000) begin
      dec_legal   = 1'b1;
      dec_use_imm = 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= S_FETCH;
      timeout_q <= '0;
      rs1_q     <= '0;
      rs2_q     <= '0;
      rd_q      <= '0;
      alu_op_q  <= '0;
      use_imm_q <= 1'b0;
      imm_q     <= '0;
      halted_q  <= 1'b0;
      trap_q    <= 1'b0;
      cycle_q   <= '0;
      retired_q <= '0;
    end else begin
      state_q   <= state_d;
      timeout_q <= timeout_d;
      rs1_q     <= rs1_d;
      rs2_q     <= rs2_d;
      rd_q      <= rd_d;
      alu_op_q  <= alu_op_d;
      use_imm_q <= use_imm_d;
      imm_q     <= imm_d;
      halted_q  <= halted_d;
      trap_q    <= trap_d;
      cycle_q   <= cycle_d;
      retired_q <= retired_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    timeout_d = timeout_q;
    rs1_d     = rs1_q;
    rs2_d     = rs2_q;
    rd_d      = rd_q;
    alu_op_d  = alu_op_q;
    use_imm_d = use_imm_q;
    imm_d     = imm_q;
    case (state_q)
      S_FETCH: begin
        if (!run_enable) begin
          timeout_d = '0;
        end else if (mem_ready) begin
          state_d   = S_DECODE;
          timeout_d = '0;
        end else if (timeout_q == TO_LAST) begin
          state_d   = S_TRAP;
          timeout_d = '0;
        end else begin
          timeout_d = timeout_q + TO_W'(1);
        end
      end
      S_DECODE: begin
        rs1_d     = instruction[19:15];
        rs2_d     = instruction[24:20];
        rd_d      = instruction[11:7];
        imm_d     = {{(XLEN-12){instruction[31]}}, instruction[31:20]};
        alu_op_d  = dec_op;
        use_imm_d = dec_use_imm;
        if (dec_ecall)      state_d = S_HALT;
        else if (dec_legal) state_d = S_EXECUTE;
        else                state_d = S_TRAP;
      end
      S_EXECUTE:   state_d = S_WRITEBACK;
      S_WRITEBACK: state_d = S_FETCH;
      S_HALT:      state_d = S_HALT;
      default:     state_d = S_TRAP;
    endcase

    halted_d = halted_q | (state_d == S_HALT);
    trap_d   = trap_q   | (state_d == S_TRAP);

    // Counters saturate rather than wrap
    cycle_d = cycle_q;
    if (state_q != S_HALT && state_q != S_TRAP && cycle_q != '1)
      cycle_d = cycle_q + CNT_W'(1);
    retired_d = retired_q;
    if (state_q == S_WRITEBACK && retired_q != '1)
      retired_d = retired_q + CNT_W'(1);
  end

  // Strobes are suppressed by reset in the same cycle so no partial writeback can occur
  always_comb begin
    mem_req = !reset && (state_q == S_FETCH) && run_enable;
    ir_we   = mem_req && mem_ready;
    pc_inc  = !reset && (state_q == S_WRITEBACK);
    reg_we  = pc_inc && (rd_q != 5'd0);
  end

  assign state         = state_q;
  assign rs1           = rs1_q;
  assign rs2           = rs2_q;
  assign rd            = rd_q;
  assign alu_op        = alu_op_q;
  assign use_imm       = use_imm_q;
  assign imm           = imm_q;
  assign halted        = halted_q;
  assign trap          = trap_q;
  assign cycle_count   = cycle_q;
  assign retired_count = retired_q;

endmodule

`default_nettype wire

// File: tb/tb_multicycle_controller.sv
// ============================================================================
// tb_multicycle_controller : randomized self-checking bench, rev 1.0
// ============================================================================
`default_nettype none

module tb_multicycle_controller;
  localparam int XL  = 32;
  localparam int CW  = 6;
  localparam int TO  = 16;
  localparam int SAT = (1 << CW) - 1;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          run_enable = 1'b0;
  logic          mem_ready = 1'b0;
  logic [XL-1:0] instruction = '0;
  logic          mem_req, ir_we, pc_inc, use_imm, reg_we, halted, trap;
  logic [4:0]    rs1, rs2, rd;
  logic [2:0]    alu_op, state;
  logic [XL-1:0] imm;
  logic [CW-1:0] cycle_count, retired_count;

  multicycle_controller #(.XLEN(XL), .CNT_W(CW), .FETCH_TIMEOUT(TO)) dut (
    .clock(clock), .reset(reset), .run_enable(run_enable), .mem_req(mem_req),
    .mem_ready(mem_ready), .ir_we(ir_we), .instruction(instruction), .pc_inc(pc_inc),
    .rs1(rs1), .rs2(rs2), .rd(rd), .alu_op(alu_op), .use_imm(use_imm), .imm(imm),
    .reg_we(reg_we), .state(state), .halted(halted), .trap(trap),
    .cycle_count(cycle_count), .retired_count(retired_count)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int failures = 0;
  int exp_cycles = 0;
  int exp_retired = 0;

  logic [2:0] obs_state [4];
  logic       obs_reg_we [4];
  logic       obs_pc_inc [4];
  logic       obs_mem_req, obs_ir_we;
  logic [4:0] obs_rs1, obs_rs2, obs_rd;
  logic [2:0] obs_alu_op;
  logic       obs_use_imm;
  logic [XL-1:0] obs_imm;

  function automatic int sat(input int v);
    return (v > SAT) ? SAT : v;
  endfunction

  // Reference decode: kind 0 = retires, 1 = ECALL halt, 2 = illegal trap
  function automatic void model(input logic [31:0] ins, output int kind,
                                output logic [2:0] op, output logic ui);
    logic [6:0] opc, f7;
    logic [2:0] f3;
    opc = ins[6:0]; f3 = ins[14:12]; f7 = ins[31:25];
    kind = 2; op = 3'd0; ui = 1'b0;
    if (ins == 32'h0000_0073) kind = 1;
    else if (opc == 7'h33) begin
      if      (f7 == 7'h00 && f3 == 3'd0) begin kind = 0; op = 3'd0; end
      else if (f7 == 7'h20 && f3 == 3'd0) begin kind = 0; op = 3'd1; end
      else if (f7 == 7'h00 && f3 == 3'd7) begin kind = 0; op = 3'd2; end
      else if (f7 == 7'h00 && f3 == 3'd6) begin kind = 0; op = 3'd3; end
      else if (f7 == 7'h00 && f3 == 3'd4) begin kind = 0; op = 3'd4; end
    end else if (opc == 7'h13 && f3 == 3'd0) begin
      kind = 0; ui = 1'b1;
    end
  endfunction

  task automatic tick();
    @(posedge clock);
    @(negedge clock);
  endtask

  task automatic do_reset();
    reset = 1'b1; run_enable = 1'b0; mem_ready = 1'b0;
    tick();
    reset = 1'b0;
    exp_cycles = 0; exp_retired = 0;
  endtask

  // Drives one instruction through four cycles and records what the DUT showed
  task automatic exec_instr(input logic [31:0] ins);
    instruction = ins; run_enable = 1'b1; mem_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      #1;
      if (k == 0) begin obs_mem_req = mem_req; obs_ir_we = ir_we; end
      obs_state[k] = state; obs_reg_we[k] = reg_we; obs_pc_inc[k] = pc_inc;
      if (k == 2) begin
        obs_rs1 = rs1; obs_rs2 = rs2; obs_rd = rd; obs_imm = imm;
        obs_alu_op = alu_op; obs_use_imm = use_imm;
      end
      tick();
      if (k == 0) mem_ready = 1'b0;
    end
  endtask

  task automatic test_instr_vs_model(input logic [31:0] ins, output int kind);
    logic [2:0] op, exp_st;
    logic ui, exp_we, exp_pc;
    logic [31:0] exp_imm;
    model(ins, kind, op, ui);
    exec_instr(ins);
    exp_cycles  += (kind == 0) ? 4 : 2;
    exp_retired += (kind == 0) ? 1 : 0;
    checks++; if (obs_mem_req !== 1'b1) begin failures++; $display("FAIL mem_req ins=%08h got=%0b exp=1", ins, obs_mem_req); end
    checks++; if (obs_ir_we !== 1'b1) begin failures++; $display("FAIL ir_we ins=%08h got=%0b exp=1", ins, obs_ir_we); end
    for (int k = 0; k < 4; k++) begin
      if (k < 2)          exp_st = 3'(k);
      else if (kind == 0) exp_st = 3'(k);
      else                exp_st = (kind == 1) ? 3'd4 : 3'd5;
      exp_we = (kind == 0) && (k == 3) && (ins[11:7] != 5'd0);
      exp_pc = (kind == 0) && (k == 3);
      checks++; if (obs_state[k] !== exp_st) begin failures++; $display("FAIL state ins=%08h cyc=%0d got=%0d exp=%0d", ins, k, obs_state[k], exp_st); end
      checks++; if (obs_reg_we[k] !== exp_we) begin failures++; $display("FAIL reg_we ins=%08h cyc=%0d got=%0b exp=%0b", ins, k, obs_reg_we[k], exp_we); end
      checks++; if (obs_pc_inc[k] !== exp_pc) begin failures++; $display("FAIL pc_inc ins=%08h cyc=%0d got=%0b exp=%0b", ins, k, obs_pc_inc[k], exp_pc); end
    end
    exp_imm = {{20{ins[31]}}, ins[31:20]};
    checks++; if (obs_rs1 !== ins[19:15]) begin failures++; $display("FAIL rs1 ins=%08h got=%0d exp=%0d", ins, obs_rs1, ins[19:15]); end
    checks++; if (obs_rs2 !== ins[24:20]) begin failures++; $display("FAIL rs2 ins=%08h got=%0d exp=%0d", ins, obs_rs2, ins[24:20]); end
    checks++; if (obs_rd !== ins[11:7]) begin failures++; $display("FAIL rd ins=%08h got=%0d exp=%0d", ins, obs_rd, ins[11:7]); end
    checks++; if (obs_imm !== exp_imm) begin failures++; $display("FAIL imm ins=%08h got=%08h exp=%08h", ins, obs_imm, exp_imm); end
    if (kind == 0) begin
      checks++; if (obs_alu_op !== op) begin failures++; $display("FAIL alu_op ins=%08h got=%0d exp=%0d", ins, obs_alu_op, op); end
      checks++; if (obs_use_imm !== ui) begin failures++; $display("FAIL use_imm ins=%08h got=%0b exp=%0b", ins, obs_use_imm, ui); end
    end
    checks++; if (cycle_count !== CW'(sat(exp_cycles))) begin failures++; $display("FAIL cycle_count ins=%08h got=%0d exp=%0d", ins, cycle_count, sat(exp_cycles)); end
    checks++; if (retired_count !== CW'(sat(exp_retired))) begin failures++; $display("FAIL retired_count ins=%08h got=%0d exp=%0d", ins, retired_count, sat(exp_retired)); end
    checks++; if (halted !== (kind == 1)) begin failures++; $display("FAIL halted ins=%08h got=%0b exp=%0b", ins, halted, kind == 1); end
    checks++; if (trap !== (kind == 2)) begin failures++; $display("FAIL trap ins=%08h got=%0b exp=%0b", ins, trap, kind == 2); end
  endtask

  task automatic test_reset();
    reset = 1'b1; run_enable = 1'b1; mem_ready = 1'b1;
    tick();
    #1;
    checks++; if (mem_req !== 1'b0) begin failures++; $display("FAIL reset_mem_req got=%0b exp=0", mem_req); end
    checks++; if (ir_we !== 1'b0) begin failures++; $display("FAIL reset_ir_we got=%0b exp=0", ir_we); end
    do_reset();
    checks++; if (state !== 3'd0) begin failures++; $display("FAIL reset_state got=%0d exp=0", state); end
    checks++; if ({cycle_count, retired_count} !== '0) begin failures++; $display("FAIL reset_counters got=%0d/%0d exp=0/0", cycle_count, retired_count); end
    checks++; if ({halted, trap} !== 2'b00) begin failures++; $display("FAIL reset_flags got=%0b%0b exp=00", halted, trap); end
    checks++; if ({rs1, rs2, rd, alu_op, use_imm} !== '0 || imm !== '0) begin failures++; $display("FAIL reset_fields got=%0d,%0d,%0d,%0d,%0b,%08h exp=0", rs1, rs2, rd, alu_op, use_imm, imm); end
  endtask

  task automatic test_addi();
    int kind;
    do_reset();
    test_instr_vs_model(32'h0050_0093, kind);
    checks++; if (obs_rd !== 5'd1 || obs_rs1 !== 5'd0 || obs_imm !== 32'd5 || obs_use_imm !== 1'b1 || obs_alu_op !== 3'd0)
      begin failures++; $display("FAIL addi_fields got rd=%0d rs1=%0d imm=%0h ui=%0b op=%0d exp 1,0,5,1,0", obs_rd, obs_rs1, obs_imm, obs_use_imm, obs_alu_op); end
    checks++; if (retired_count !== 6'd1) begin failures++; $display("FAIL addi_retired got=%0d exp=1", retired_count); end
  endtask

  task automatic test_alu_ops();
    int kind;
    logic [31:0] tbl [7];
    tbl = '{32'h0020_8233, 32'h4020_8233, 32'h0020_F233, 32'h0020_E233,
            32'h0020_C233, 32'hFFF0_0093, 32'h0020_8033};
    do_reset();
    for (int i = 0; i < 7; i++) test_instr_vs_model(tbl[i], kind);
    checks++; if (obs_reg_we[3] !== 1'b0 || obs_pc_inc[3] !== 1'b1) begin failures++; $display("FAIL rd0_writeback got we=%0b pc=%0b exp 0,1", obs_reg_we[3], obs_pc_inc[3]); end
    checks++; if (retired_count !== 6'd7) begin failures++; $display("FAIL alu_retired got=%0d exp=7", retired_count); end
  endtask

  task automatic test_terminal(input logic [31:0] ins, input logic [2:0] exp_st);
    int kind;
    do_reset();
    test_instr_vs_model(32'h0010_0113, kind);
    test_instr_vs_model(ins, kind);
    run_enable = 1'b1; mem_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      #1;
      checks++; if (state !== exp_st || mem_req || pc_inc || reg_we || ir_we) begin failures++; $display("FAIL terminal_hold ins=%08h i=%0d got st=%0d strobes=%0b%0b%0b%0b exp st=%0d strobes=0000", ins, i, state, mem_req, pc_inc, reg_we, ir_we, exp_st); end
      checks++; if (halted !== (exp_st == 3'd4) || trap !== (exp_st == 3'd5)) begin failures++; $display("FAIL terminal_flags ins=%08h got=%0b%0b", ins, halted, trap); end
      checks++; if (cycle_count !== CW'(exp_cycles) || retired_count !== 6'd1) begin failures++; $display("FAIL terminal_frozen got=%0d/%0d exp=%0d/1", cycle_count, retired_count, exp_cycles); end
      tick();
    end
  endtask

  task automatic test_timeout();
    do_reset();
    run_enable = 1'b1; mem_ready = 1'b0;
    for (int i = 0; i < TO; i++) begin
      #1;
      checks++; if (state !== 3'd0 || mem_req !== 1'b1) begin failures++; $display("FAIL timeout_wait i=%0d got st=%0d req=%0b exp 0,1", i, state, mem_req); end
      tick();
    end
    checks++; if (state !== 3'd5 || trap !== 1'b1) begin failures++; $display("FAIL timeout_trap got st=%0d trap=%0b exp 5,1", state, trap); end
    checks++; if (cycle_count !== CW'(TO)) begin failures++; $display("FAIL timeout_cycles got=%0d exp=%0d", cycle_count, TO); end
  endtask

  task automatic test_run_disable();
    int kind;
    do_reset();
    run_enable = 1'b0;
    for (int i = 0; i < 30; i++) begin
      mem_ready = 1'($urandom_range(0, 1));
      #1;
      checks++; if (state !== 3'd0 || mem_req !== 1'b0 || ir_we !== 1'b0) begin failures++; $display("FAIL disabled i=%0d got st=%0d req=%0b irwe=%0b exp 0,0,0", i, state, mem_req, ir_we); end
      tick();
    end
    run_enable = 1'b1; mem_ready = 1'b0;
    for (int i = 0; i < TO - 1; i++) tick();
    exp_cycles = 30 + TO - 1;
    test_instr_vs_model(32'h0030_0193, kind);
  endtask

  task automatic test_reset_in_writeback();
    do_reset();
    instruction = 32'h0050_0093; run_enable = 1'b1; mem_ready = 1'b1;
    tick(); mem_ready = 1'b0; tick(); tick();
    #1;
    checks++; if (state !== 3'd3) begin failures++; $display("FAIL rst_wb_state got=%0d exp=3", state); end
    reset = 1'b1;
    #1;
    checks++; if (reg_we !== 1'b0 || pc_inc !== 1'b0) begin failures++; $display("FAIL rst_wb_strobes got we=%0b pc=%0b exp 0,0", reg_we, pc_inc); end
    tick();
    reset = 1'b0;
    checks++; if (state !== 3'd0 || cycle_count !== '0 || retired_count !== '0) begin failures++; $display("FAIL rst_wb_after got st=%0d cyc=%0d ret=%0d exp 0,0,0", state, cycle_count, retired_count); end
  endtask

  task automatic test_random();
    int kind, sel;
    logic [31:0] ins;
    logic [2:0] f3 [5];
    logic [6:0] f7 [5];
    f3 = '{3'd0, 3'd0, 3'd7, 3'd6, 3'd4};
    f7 = '{7'h00, 7'h20, 7'h00, 7'h00, 7'h00};
    do_reset();
    for (int n = 0; n < 60; n++) begin
      sel = $urandom_range(0, 19);
      if (sel < 10) begin
        kind = $urandom_range(0, 4);
        ins = {f7[kind], 5'($urandom), 5'($urandom), f3[kind], 5'($urandom), 7'h33};
      end else if (sel < 15) ins = {12'($urandom), 5'($urandom), 3'd0, 5'($urandom), 7'h13};
      else if (sel < 17) ins = {7'($urandom), 5'($urandom), 5'($urandom), 3'($urandom), 5'($urandom), 7'h33};
      else if (sel < 19) ins = $urandom;
      else ins = 32'h0000_0073;
      test_instr_vs_model(ins, kind);
      if (kind != 0) do_reset();
    end
  endtask

  task automatic test_saturation();
    int kind;
    do_reset();
    for (int n = 0; n < 20; n++)
      test_instr_vs_model({12'($urandom), 5'($urandom), 3'd0, 5'($urandom), 7'h13}, kind);
    checks++; if (cycle_count !== CW'(SAT) || retired_count !== 6'd20) begin failures++; $display("FAIL saturation got=%0d/%0d exp=%0d/20", cycle_count, retired_count, SAT); end
  endtask

  initial begin
    @(negedge clock);
    test_reset();
    test_addi();
    test_alu_ops();
    test_terminal(32'h0000_0073, 3'd4);
    test_terminal(32'h0000_0000, 3'd5);
    test_timeout();
    test_run_disable();
    test_reset_in_writeback();
    test_random();
    test_saturation();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire
